mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO register pair, sitting alongside the ALU decode path.
- Decodes R-type Funct for mult, multu, div, divu, mfhi, mflo, mthi and mtlo, which the single-cycle ALU decode does not implement.
- Runs an iterative shift-add multiplier or a restoring divider over a parametrised operand width.
- Drives a stall to the datapath while busy and supplies HI/LO read data to the write-back mux.

Parameters:
- WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits wide.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  reset, asynchronous and active-low.
- rtype_valid  input  1  current instruction is R-type; qualifies Funct.
- Funct  input  6  instruction funct field.
- op_a  input  WIDTH  rs operand.
- op_b  input  WIDTH  rt operand.
- stall  output  1  freeze PC and pipeline this cycle.
- busy  output  1  multiply/divide iteration in progress.
- rd_data  output  WIDTH  HI or LO value for mfhi/mflo.
- rd_valid  output  1  rd_data is valid this cycle.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Funct codes: mfhi 6'h10, mthi 6'h11, mflo 6'h12, mtlo 6'h13, mult 6'h18, multu 6'h19, div 6'h1A, divu 6'h1B. Any other funct is ignored.
- Reset (rstn=0, asynchronous): state=IDLE; hi=0; lo=0; counter=0; busy=0; stall=0; rd_valid=0; rd_data=0. A reset during an operation aborts it, and no partial result is written.
- States:
  - IDLE: accepts commands.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring division, one bit per cycle.
  - FIX: sign correction and HI/LO commit.
- Transitions:
  - IDLE -> MUL on mult/multu; IDLE -> DIV on div/divu.
  - MUL or DIV -> FIX when the counter reaches WIDTH-1.
  - FIX -> IDLE unconditionally.
- Issue and latency:
  - A start command is accepted at clock edge N when the state is IDLE. Operands are latched at that edge.
  - busy=1 from cycle N+1 through N+WIDTH+1: WIDTH iteration cycles plus one FIX cycle.
  - hi/lo update at the edge that ends FIX. busy=0 the following cycle.
- Stall: stall=1 combinationally whenever rtype_valid=1, Funct is one of the eight MDU codes, and the state is not IDLE. A stalled command is not accepted; the datapath re-presents it and it issues on the first IDLE cycle.
- mthi/mtlo in IDLE write op_a into hi/lo at the edge.
- mfhi/mflo in IDLE:
  - rd_valid=1 and rd_data=hi/lo combinationally in the same cycle.
  - Otherwise rd_valid=0 and rd_data holds its last value.
- Non-MDU funct codes never stall and never change state, including while busy.
- Signed operations:
  - Iterate on absolute values.
  - In FIX, negate the product if the operand signs differ.
  - Quotient is negative if the signs differ; remainder takes the dividend's sign.
- Multiply results: hi={product[2*WIDTH-1:WIDTH]}, lo={product[WIDTH-1:0]}.
- Divide results: lo=quotient, hi=remainder.
- Divide by zero: lo all ones, hi=op_a (signed div keeps the dividend's raw value). The full latency still applies.
- Signed overflow (most-negative / -1): lo=most-negative value, hi=0.

Optional Feature:
- Macro: MDU_DIV0_FLAG_EN.
- Defined:
  - Adds output port div0 (1 bit).
  - div0 is a sticky flag set at the FIX commit of any div/divu with op_b=0.
  - Cleared by reset or by the next accepted div/divu with op_b!=0 at its commit.
  - While div0=1, HI/LO are still written per the divide-by-zero rule.
- Undefined: no div0 port and no associated logic. The divide-by-zero result rule is unchanged.

Test Plan:
- Reset/mthi/mtlo/mfhi: rstn low mid-DIV -> hi=lo=0, busy=0 immediately. Then mthi op_a=32'hDEADBEEF and mfhi -> rd_valid=1, rd_data=32'hDEADBEEF.
- multu 32'hFFFFFFFF x 32'h00000002 -> busy for exactly 33 cycles, then hi=32'h00000001, lo=32'hFFFFFFFE.
- mult -7 x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB. div -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- divu 100 / 0 -> lo=32'hFFFFFFFF, hi=32'd100, div0=1 when MDU_DIV0_FLAG_EN is set. A following divu 9/4 -> lo=2, hi=1, div0=0.
- mflo issued while busy -> stall=1 every busy cycle. It is accepted on the first IDLE cycle with rd_data equal to the new lo. An add funct 6'h20 during busy -> stall=0.
- div 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0. Repeat with WIDTH=8: div 8'h80 / 8'hFF -> lo=8'h80, hi=0, busy for 9 cycles.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with a private HI/LO pair.
// Decodes R-type funct for mult/multu/div/divu/mfhi/mflo/mthi/mtlo and
// runs a one-bit-per-cycle shift-add multiplier or restoring divider.
//
// Ports:
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   rtype_valid    current instruction is R-type, qualifies Funct
//   Funct          instruction funct field
//   op_a, op_b     rs / rt operands
//   stall          combinational: MDU command presented while not idle
//   busy           iteration or fix-up in progress
//   rd_data        HI/LO read data for mfhi/mflo (holds last value otherwise)
//   rd_valid       combinational: mfhi/mflo served this cycle
//   hi, lo         current HI / LO registers
//   div0           (only with MDU_DIV0_FLAG_EN) sticky divide-by-zero flag
//
// Optional feature macro: MDU_DIV0_FLAG_EN
module mdu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rtype_valid,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_start_mul;
  logic             w_start_div;
  logic             w_iter;
  logic             w_commit;

  logic [PW-1:0]    r_prod;      // mul: {acc, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0] r_b;         // |multiplicand| or |divisor|
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic             r_neg_res;
  logic             r_neg_a;
  logic             r_b_zero;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_rd_last;

  // Command decode: 0x10-0x13 and 0x18-0x1B are the MDU codes.
  logic w_idle;
  logic w_is_mdu;
  logic w_signed;
  assign w_idle   = (r_state == S_IDLE);
  assign w_is_mdu = rtype_valid & ((Funct[5:2] == 4'b0100) | (Funct[5:2] == 4'b0110));
  assign w_signed = (Funct == F_MULT) | (Funct == F_DIV);

  assign stall = w_is_mdu & ~w_idle;
  assign busy  = ~w_idle;

  // HI/LO read port: live value when served, otherwise the last served value.
  logic [WIDTH-1:0] w_rd_sel;
  assign rd_valid = w_idle & rtype_valid & ((Funct == F_MFHI) | (Funct == F_MFLO));
  assign w_rd_sel = (Funct == F_MFHI) ? hi : lo;
  assign rd_data  = rd_valid ? w_rd_sel : r_rd_last;

  logic w_wr_hi;
  logic w_wr_lo;
  assign w_wr_hi = w_idle & rtype_valid & (Funct == F_MTHI);
  assign w_wr_lo = w_idle & rtype_valid & (Funct == F_MTLO);

  // Absolute operand values for signed ops.
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  assign w_abs_a = (w_signed & op_a[WIDTH-1]) ? (WIDTH'(0) - op_a) : op_a;
  assign w_abs_b = (w_signed & op_b[WIDTH-1]) ? (WIDTH'(0) - op_b) : op_b;

  // Shift-add step: conditionally add multiplicand to the upper half, shift right.
  logic [WIDTH:0]   w_mul_sum;
  logic [PW-1:0]    w_mul_nxt;
  assign w_mul_sum = {1'b0, r_prod[PW-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : (WIDTH+1)'(0));
  assign w_mul_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring step: shift in next dividend bit, keep the difference if non-negative.
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic [PW-1:0]    w_div_nxt;
  assign w_div_shift = {r_prod[PW-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_b};
  assign w_div_nxt   = w_div_trial[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                     : {w_div_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  // Sign fix-up and result selection for the commit edge.
  logic [PW-1:0]    w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;
  assign w_prod_fix = r_neg_res ? (PW'(0) - r_prod) : r_prod;
  assign w_quo = r_neg_res ? (WIDTH'(0) - r_prod[WIDTH-1:0]) : r_prod[WIDTH-1:0];
  assign w_rem = r_neg_a ? (WIDTH'(0) - r_prod[PW-1:WIDTH]) : r_prod[PW-1:WIDTH];

  always_comb begin
    w_hi_res = w_prod_fix[PW-1:WIDTH];
    w_lo_res = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        // Divide by zero returns the raw dividend, even for signed div.
        w_hi_res = r_a_raw;
        w_lo_res = '1;
      end else begin
        w_hi_res = w_rem;
        w_lo_res = w_quo;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    w_iter      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rtype_valid) begin
          if ((Funct == F_MULT) || (Funct == F_MULTU)) begin
            w_start_mul = 1'b1;
            w_state_nxt = S_MUL;
          end else if ((Funct == F_DIV) || (Funct == F_DIVU)) begin
            w_start_div = 1'b1;
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        w_iter = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration datapath: operand latch at issue, one step per MUL/DIV cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod    <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_a_raw   <= '0;
    end else if (w_start_mul || w_start_div) begin
      r_prod    <= {WIDTH'(0), w_abs_a};
      r_b       <= w_abs_b;
      r_cnt     <= '0;
      r_is_div  <= w_start_div;
      r_neg_res <= w_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      r_neg_a   <= w_signed & op_a[WIDTH-1];
      r_b_zero  <= (op_b == '0);
      r_a_raw   <= op_a;
    end else if (w_iter) begin
      r_prod <= r_is_div ? w_div_nxt : w_mul_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // HI/LO registers: commit from FIX or direct move-to writes in IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi <= '0;
      lo <= '0;
    end else if (w_commit) begin
      hi <= w_hi_res;
      lo <= w_lo_res;
    end else begin
      if (w_wr_hi) hi <= op_a;
      if (w_wr_lo) lo <= op_a;
    end
  end

  // Last served read value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_rd_last <= '0;
    else if (rd_valid) r_rd_last <= w_rd_sel;
  end

`ifdef MDU_DIV0_FLAG_EN
  // Sticky divide-by-zero flag, updated only by divide commits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    div0 <= 1'b0;
    else if (w_commit && r_is_div) div0 <= r_b_zero;
  end
`endif

endmodule
